// File: rtl/physics_episode_ctrl_if.sv
// Agent/host side of the episode controller: observation out, action in, result out.
// master = agent/host, slave = controller.
interface physics_episode_ctrl_if #(
  parameter int STEPS_W = 16
) ();
  logic                      obs_valid;
  logic signed [15:0]        obs_x;
  logic signed [15:0]        obs_y;
  logic                      act_valid;
  logic                      act_ready;
  logic signed [23:0]        act_fx;
  logic signed [23:0]        act_fy;
  logic                      res_valid;
  logic                      res_ready;
  logic                      res_goal;
  logic [STEPS_W-1:0]        res_steps;
  logic [STEPS_W-1:0]        res_stalls;

  modport master (
    input  obs_valid, obs_x, obs_y, act_ready, res_valid, res_goal, res_steps, res_stalls,
    output act_valid, act_fx, act_fy, res_ready
  );

  modport slave (
    output obs_valid, obs_x, obs_y, act_ready, res_valid, res_goal, res_steps, res_stalls,
    input  act_valid, act_fx, act_fy, res_ready
  );
endinterface

// File: rtl/physics_episode_ctrl.sv
// Episode sequencer for the 2-D rolling-ball integrator: plant reset, two init pulses,
// then one observation/action exchange and one plant clk_en pulse per step until goal or budget.
module physics_episode_ctrl #(
  parameter int RST_CYC = 4,
  parameter int ACT_TMO = 1024,
  parameter int STEPS_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_i,
  input  logic                     abort_i,
  input  logic [5:0]               mass_g_i,
  input  logic [STEPS_W-1:0]       max_steps_i,
  physics_episode_ctrl_if.slave    agent,
  output logic                     plant_rst_n_o,
  output logic                     plant_clk_en_o,
  output logic signed [23:0]       plant_fx_o,
  output logic signed [23:0]       plant_fy_o,
  output logic [5:0]               plant_mass_o,
  input  logic signed [15:0]       plant_px_i,
  input  logic signed [15:0]       plant_py_i,
  input  logic                     plant_goal_i,
  output logic                     busy_o
);

  localparam int RCW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
  localparam int TCW = (ACT_TMO > 1) ? $clog2(ACT_TMO) : 1;
  localparam logic [RCW-1:0]     RC_LAST = RCW'(RST_CYC - 1);
  localparam logic [TCW-1:0]     TC_LAST = TCW'(ACT_TMO - 1);
  localparam logic [STEPS_W-1:0] CNT_SAT = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_RST, S_INIT0, S_INIT1, S_WAIT_ACT, S_STEP, S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [RCW-1:0]      r_rst_cnt;
  logic [TCW-1:0]      r_tmo_cnt;
  logic [STEPS_W-1:0]  r_step_cnt;
  logic [STEPS_W-1:0]  r_stall_cnt;
  logic [STEPS_W-1:0]  r_max_steps;
  logic [5:0]          r_mass;
  logic signed [23:0]  r_fx;
  logic signed [23:0]  r_fy;
  logic                r_res_goal;
  logic                w_offer;
  logic                w_accept;
  logic                w_timeout;

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    w_next    = r_state;
    w_offer   = 1'b0;
    w_accept  = 1'b0;
    w_timeout = 1'b0;
    unique case (r_state)
      S_IDLE:  if (start_i) w_next = S_RST;
      S_RST:   if (r_rst_cnt == RC_LAST) w_next = S_INIT0;
      S_INIT0: w_next = S_INIT1;
      S_INIT1: w_next = S_WAIT_ACT;
      S_WAIT_ACT: begin
        // The goal flag is taken as presented; it wins over an exhausted budget.
        if (plant_goal_i || (r_step_cnt == r_max_steps)) begin
          w_next = S_DONE;
        end else begin
          w_offer = 1'b1;
          if (agent.act_valid) begin
            w_accept = 1'b1;
            w_next   = S_STEP;
          end else if (r_tmo_cnt == TC_LAST) begin
            w_timeout = 1'b1;
            w_next    = S_STEP;
          end
        end
      end
      S_STEP:  w_next = S_WAIT_ACT;
      S_DONE:  if (agent.res_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (abort_i && (r_state != S_IDLE)) begin
      w_next    = S_IDLE;
      w_accept  = 1'b0;
      w_timeout = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rst_cnt   <= '0;
      r_tmo_cnt   <= '0;
      r_step_cnt  <= '0;
      r_stall_cnt <= '0;
      r_max_steps <= '0;
      r_mass      <= '0;
      r_fx        <= '0;
      r_fy        <= '0;
      r_res_goal  <= 1'b0;
    end else begin
      if ((r_state == S_IDLE) && start_i) begin
        r_mass      <= mass_g_i;
        r_max_steps <= max_steps_i;
        r_rst_cnt   <= '0;
        r_tmo_cnt   <= '0;
        r_step_cnt  <= '0;
        r_stall_cnt <= '0;
        r_fx        <= '0;
        r_fy        <= '0;
        r_res_goal  <= 1'b0;
      end
      if (r_state == S_RST) r_rst_cnt <= r_rst_cnt + 1'b1;
      if (w_accept) begin
        r_fx      <= agent.act_fx;
        r_fy      <= agent.act_fy;
        r_tmo_cnt <= '0;
      end else if (w_timeout) begin
        r_fx      <= '0;
        r_fy      <= '0;
        r_tmo_cnt <= '0;
        if (r_stall_cnt != CNT_SAT) r_stall_cnt <= r_stall_cnt + 1'b1;
      end else if (w_offer) begin
        r_tmo_cnt <= r_tmo_cnt + 1'b1;
      end
      if ((r_state == S_STEP) && !abort_i && (r_step_cnt != CNT_SAT))
        r_step_cnt <= r_step_cnt + 1'b1;
      if ((r_state == S_WAIT_ACT) && (w_next == S_DONE))
        r_res_goal <= plant_goal_i;
    end
  end

  assign busy_o         = (r_state != S_IDLE);
  assign plant_rst_n_o  = !((r_state == S_IDLE) || (r_state == S_RST));
  assign plant_clk_en_o = ((r_state == S_INIT0) || (r_state == S_INIT1) || (r_state == S_STEP))
                          && !abort_i;
  assign plant_fx_o     = r_fx;
  assign plant_fy_o     = r_fy;
  assign plant_mass_o   = r_mass;

  assign agent.obs_valid  = w_offer;
  assign agent.obs_x      = w_offer ? plant_px_i : '0;
  assign agent.obs_y      = w_offer ? plant_py_i : '0;
  assign agent.act_ready  = w_offer && !abort_i;
  assign agent.res_valid  = (r_state == S_DONE);
  assign agent.res_goal   = r_res_goal;
  assign agent.res_steps  = r_step_cnt;
  assign agent.res_stalls = r_stall_cnt;

endmodule
